// File: rtl/i281_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i281_pkg
// Description : Shared i281 ISA constants: opcode nibbles, op_out bit
//               positions, flag-register bit positions and bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package i281_pkg;

  localparam int OP_W    = 27;   // {RX[1:0], RY[1:0], one-hot[22:0]}
  localparam int ONEHOT_W = 23;

  // Opcode nibbles, IR[15:12]
  localparam logic [3:0] OPC_NOOP   = 4'h0;
  localparam logic [3:0] OPC_INPUT  = 4'h1;
  localparam logic [3:0] OPC_MOVE   = 4'h2;
  localparam logic [3:0] OPC_LOADI  = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_ADDI   = 4'h5;
  localparam logic [3:0] OPC_SUB    = 4'h6;
  localparam logic [3:0] OPC_SUBI   = 4'h7;
  localparam logic [3:0] OPC_LOAD   = 4'h8;
  localparam logic [3:0] OPC_LOADF  = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_STOREF = 4'hB;
  localparam logic [3:0] OPC_SHIFT  = 4'hC;
  localparam logic [3:0] OPC_CMP    = 4'hD;
  localparam logic [3:0] OPC_JUMP   = 4'hE;
  localparam logic [3:0] OPC_BRANCH = 4'hF;

  // Bit positions inside op_out[22:0]
  localparam int NOOP_B    = 0;
  localparam int INPUTC_B  = 1;
  localparam int INPUTCF_B = 2;
  localparam int INPUTD_B  = 3;
  localparam int INPUTDF_B = 4;
  localparam int MOVE_B    = 5;
  localparam int LOADI_B   = 6;
  localparam int ADD_B     = 7;
  localparam int ADDI_B    = 8;
  localparam int SUB_B     = 9;
  localparam int SUBI_B    = 10;
  localparam int LOAD_B    = 11;
  localparam int LOADF_B   = 12;
  localparam int STORE_B   = 13;
  localparam int STOREF_B  = 14;
  localparam int SHIFTL_B  = 15;
  localparam int SHIFTR_B  = 16;
  localparam int CMP_B     = 17;
  localparam int JUMP_B    = 18;
  localparam int BRE_B     = 19;
  localparam int BRNE_B    = 20;
  localparam int BRG_B     = 21;
  localparam int BRGE_B    = 22;

  // Flag register bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_C = 3;

  // JUMP -1: a program parks itself here when it is finished
  localparam logic [15:0] SELF_HALT_WORD = 16'hE0FF;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational i281 instruction decoder. Produces the
//               RX/RY fields and a one-hot opcode bus; exactly one one-hot
//               bit is set for every input value.
// Ports       : ir_hi  [7:0]   in  - IR[15:8] (opcode, RX, RY); the
//                                    immediate byte is not needed here
//               op_out [26:0]  out - {RX, RY, one-hot opcode}
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import i281_pkg::*;
(
  input  logic [7:0]      ir_hi,
  output logic [OP_W-1:0] op_out
);

  logic [3:0] w_opc;
  logic [1:0] w_rx;
  logic [1:0] w_ry;

  assign w_opc = ir_hi[7:4];
  assign w_rx  = ir_hi[3:2];
  assign w_ry  = ir_hi[1:0];

  always_comb begin
    op_out        = '0;
    op_out[26:25] = w_rx;
    op_out[24:23] = w_ry;
    case (w_opc)
      OPC_NOOP:   op_out[NOOP_B]   = 1'b1;
      // INPUT family is sub-decoded by the RY field
      OPC_INPUT: begin
        case (w_ry)
          2'b00:   op_out[INPUTC_B]  = 1'b1;
          2'b01:   op_out[INPUTCF_B] = 1'b1;
          2'b10:   op_out[INPUTD_B]  = 1'b1;
          default: op_out[INPUTDF_B] = 1'b1;
        endcase
      end
      OPC_MOVE:   op_out[MOVE_B]   = 1'b1;
      OPC_LOADI:  op_out[LOADI_B]  = 1'b1;
      OPC_ADD:    op_out[ADD_B]    = 1'b1;
      OPC_ADDI:   op_out[ADDI_B]   = 1'b1;
      OPC_SUB:    op_out[SUB_B]    = 1'b1;
      OPC_SUBI:   op_out[SUBI_B]   = 1'b1;
      OPC_LOAD:   op_out[LOAD_B]   = 1'b1;
      OPC_LOADF:  op_out[LOADF_B]  = 1'b1;
      OPC_STORE:  op_out[STORE_B]  = 1'b1;
      OPC_STOREF: op_out[STOREF_B] = 1'b1;
      // Shift direction lives in RY[0]; RY[1] is don't-care
      OPC_SHIFT: begin
        if (w_ry[0]) op_out[SHIFTR_B] = 1'b1;
        else         op_out[SHIFTL_B] = 1'b1;
      end
      OPC_CMP:    op_out[CMP_B]    = 1'b1;
      OPC_JUMP:   op_out[JUMP_B]   = 1'b1;
      default: begin
        case (w_ry)
          2'b00:   op_out[BRE_B]  = 1'b1;
          2'b01:   op_out[BRNE_B] = 1'b1;
          2'b10:   op_out[BRG_B]  = 1'b1;
          default: op_out[BRGE_B] = 1'b1;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : i281 instruction register, decoder, flag register and
//               run/step/halt control. cpu_en gates every architectural
//               register in the datapath.
// Ports       : clk       in  - system clock, rising edge
//               reset     in  - asynchronous, active-high
//               instr_in  in  - code-memory word at current PC
//               run_req   in  - level, 1 = free-run
//               step_req  in  - level, rising edge = execute one instruction
//               halt_req  in  - level, forces HALT (highest priority)
//               flag_we   in  - flag register write enable
//               flag_d    in  - ALU flags {C,O,N,Z}
//               op_out    out - {RX, RY, one-hot opcode}
//               imm_out   out - IR[7:0]
//               flag_out  out - flag register
//               cpu_en    out - datapath enable this cycle
//               halted    out - control FSM is in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode
  import i281_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr_in,
  input  logic            run_req,
  input  logic            step_req,
  input  logic            halt_req,
  input  logic            flag_we,
  input  logic [3:0]      flag_d,
  output logic [OP_W-1:0] op_out,
  output logic [7:0]      imm_out,
  output logic [3:0]      flag_out,
  output logic            cpu_en,
  output logic            halted
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_ir;
  logic [3:0]  r_flags;
  logic        r_step_q;
  logic        w_step_edge;
  logic        w_self_halt;

  // r_step_q follows step_req every cycle, so an edge seen while running or
  // stepping is simply consumed and never replayed once back in HALT.
  assign w_step_edge = step_req & ~r_step_q;
  assign w_self_halt = (r_ir == SELF_HALT_WORD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HALT;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (halt_req) begin
      w_next_state = S_HALT;
    end else begin
      case (r_state)
        S_HALT: begin
          if (run_req)          w_next_state = S_RUN;
          else if (w_step_edge) w_next_state = S_STEP;
        end
        S_RUN: begin
          if (!run_req || w_self_halt) w_next_state = S_HALT;
        end
        default: w_next_state = S_HALT;  // STEP lasts exactly one cycle
      endcase
    end
  end

  // Output logic (Moore)
  always_comb begin
    cpu_en = 1'b0;
    halted = 1'b0;
    case (r_state)
      S_RUN, S_STEP: cpu_en = 1'b1;
      default:       halted = 1'b1;
    endcase
  end

  // Architectural registers: only advance when the datapath is enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir     <= 16'h0000;
      r_flags  <= 4'h0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step_req;
      if (cpu_en) begin
        r_ir <= instr_in;
        if (flag_we) r_flags <= flag_d;
      end
    end
  end

  instr_decoder u_decoder (
    .ir_hi  (r_ir[15:8]),
    .op_out (op_out)
  );

  assign imm_out  = r_ir[7:0];
  assign flag_out = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Self-checking bench for fetch_decode: decode vector table,
//               hand-written control sequences, and a randomized run against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        run_req, step_req, halt_req, flag_we;
  logic [3:0]  flag_d;
  logic [26:0] op_out;
  logic [7:0]  imm_out;
  logic [3:0]  flag_out;
  logic        cpu_en, halted;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_decode dut (
    .clk      (clk),
    .reset    (reset),
    .instr_in (instr_in),
    .run_req  (run_req),
    .step_req (step_req),
    .halt_req (halt_req),
    .flag_we  (flag_we),
    .flag_d   (flag_d),
    .op_out   (op_out),
    .imm_out  (imm_out),
    .flag_out (flag_out),
    .cpu_en   (cpu_en),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [26:0] op;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: position of the one-hot bit from a base table plus the
  // sub-field offset for the INPUT, SHIFT and BRANCH families.
  function automatic logic [26:0] ref_op(input logic [15:0] w);
    int base[16];
    int opc;
    int idx;
    logic [22:0] oh;
    base = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    opc  = int'(w[15:12]);
    idx  = base[opc];
    if (opc == 1 || opc == 15) idx += int'(w[9:8]);
    else if (opc == 12)        idx += int'(w[8]);
    oh = 23'(1) << idx;
    return {w[11:10], w[9:8], oh};
  endfunction

  // Behavioural model state for the random phase
  typedef enum int {M_HALT, M_RUN, M_STEP} mode_t;
  mode_t       m_mode;
  logic [15:0] m_ir;
  logic [3:0]  m_fl;
  logic        m_prev;

  initial begin
    logic [4:0] pat;

    tbl[0]  = '{16'h4600, {2'b01, 2'b10, 23'h000080}};  // ADD
    tbl[1]  = '{16'h1300, {2'b00, 2'b11, 23'h000010}};  // INPUTDF
    tbl[2]  = '{16'hF300, {2'b00, 2'b11, 23'h400000}};  // BRGE
    tbl[3]  = '{16'h0000, {2'b00, 2'b00, 23'h000001}};  // NOOP
    tbl[4]  = '{16'h1000, {2'b00, 2'b00, 23'h000002}};  // INPUTC
    tbl[5]  = '{16'h1100, {2'b00, 2'b01, 23'h000004}};  // INPUTCF
    tbl[6]  = '{16'h1200, {2'b00, 2'b10, 23'h000008}};  // INPUTD
    tbl[7]  = '{16'h2D05, {2'b11, 2'b01, 23'h000020}};  // MOVE
    tbl[8]  = '{16'hC100, {2'b00, 2'b01, 23'h010000}};  // SHIFTR
    tbl[9]  = '{16'hC200, {2'b00, 2'b10, 23'h008000}};  // SHIFTL (RY[1] ignored)
    tbl[10] = '{16'hD5AA, {2'b01, 2'b01, 23'h020000}};  // CMP
    tbl[11] = '{16'hF100, {2'b00, 2'b01, 23'h100000}};  // BRNE
    tbl[12] = '{16'hF200, {2'b00, 2'b10, 23'h200000}};  // BRG
    tbl[13] = '{16'hE012, {2'b00, 2'b00, 23'h040000}};  // JUMP (not -1)
    tbl[14] = '{16'h8F33, {2'b11, 2'b11, 23'h000800}};  // LOAD

    reset = 1'b1; instr_in = '0; run_req = 0; step_req = 0; halt_req = 0;
    flag_we = 0; flag_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // ---- reset state ----
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_op",     32'(op_out), 32'h1);
    check("rst_imm",    32'(imm_out), 32'h0);
    check("rst_flag",   32'(flag_out), 32'h0);
    tick();
    check("halt_hold", 32'({halted, cpu_en}), 32'b10);

    // ---- decode table, free-running ----
    run_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      instr_in = tbl[i].instr;
      tick();
      check($sformatf("dec_op[%0d]", i), 32'(op_out), 32'(tbl[i].op));
      check($sformatf("dec_imm[%0d]", i), 32'(imm_out), 32'(tbl[i].instr[7:0]));
    end
    run_req = 1'b0; instr_in = '0;
    tick();
    check("run_off_halt", 32'({halted, cpu_en}), 32'b10);

    // ---- single step with step_req held high ----
    step_req = 1'b1; instr_in = 16'h00A0;
    tick();
    pat = '0;
    for (int k = 1; k <= 5; k++) begin
      pat[k-1] = cpu_en;
      instr_in = 16'h00A0 + 16'(k);
      tick();
    end
    check("step_pulse", 32'(pat), 32'b00001);
    check("step_ir", 32'(imm_out), 32'hA1);
    step_req = 1'b0;
    tick();

    // ---- flag register ----
    run_req = 1'b1; instr_in = '0;
    tick();
    flag_we = 1'b1; flag_d = 4'b1010;
    tick();
    check("flag_run_wr", 32'(flag_out), 32'b1010);
    run_req = 1'b0; flag_d = 4'b0011;       // write on the cycle leaving RUN
    tick();
    check("flag_wr_to_halt", 32'(flag_out), 32'b0011);
    check("flag_halted", 32'(halted), 32'd1);
    flag_d = 4'b0101;
    tick();
    check("flag_halt_hold", 32'(flag_out), 32'b0011);
    flag_we = 1'b0;

    // ---- self-halt on JUMP -1 ----
    run_req = 1'b1;
    tick();
    instr_in = 16'hE0FF;
    tick();
    check("selfhalt_en", 32'({cpu_en, imm_out}), 32'h1FF);
    instr_in = 16'h0000;
    tick();
    check("selfhalt_stop", 32'({halted, cpu_en}), 32'b10);

    // ---- asynchronous reset mid-run ----
    instr_in = 16'h7123; flag_we = 1'b1; flag_d = 4'hF;
    tick();
    tick();
    check("pre_rst_run", 32'({cpu_en, imm_out, flag_out}), 32'h1_23_F);
    #2 reset = 1'b1;
    #1;
    check("arst_op",   32'(op_out), 32'h1);
    check("arst_imm",  32'(imm_out), 32'h0);
    check("arst_flag", 32'(flag_out), 32'h0);
    check("arst_ctl",  32'({halted, cpu_en}), 32'b10);
    run_req = 0; instr_in = '0; flag_we = 0; flag_d = '0;
    @(negedge clk) reset = 1'b0;

    // ---- randomized run against the model ----
    m_mode = M_HALT; m_ir = '0; m_fl = '0; m_prev = 1'b0;
    tick();
    for (int c = 0; c < 600; c++) begin
      check("rnd_op", 32'(op_out), 32'(ref_op(m_ir)));
      check("rnd_misc", 32'({imm_out, flag_out, cpu_en, halted}),
            32'({m_ir[7:0], m_fl, m_mode != M_HALT, m_mode == M_HALT}));
      if ($urandom_range(0, 9) == 0) run_req = ~run_req;
      if ($urandom_range(0, 2) == 0) step_req = ~step_req;
      halt_req = ($urandom_range(0, 15) == 0);
      flag_we  = 1'(($urandom));
      flag_d   = 4'($urandom);
      instr_in = ($urandom_range(0, 5) == 0) ? 16'hE0FF : 16'($urandom);
      @(posedge clk);
      begin
        mode_t nxt;
        logic  edge_seen;
        edge_seen = step_req && !m_prev;
        m_prev    = step_req;
        if (halt_req)               nxt = M_HALT;
        else if (m_mode == M_HALT)  nxt = run_req ? M_RUN : (edge_seen ? M_STEP : M_HALT);
        else if (m_mode == M_RUN)   nxt = (!run_req || m_ir == 16'hE0FF) ? M_HALT : M_RUN;
        else                        nxt = M_HALT;
        if (m_mode != M_HALT) begin
          m_ir = instr_in;
          if (flag_we) m_fl = flag_d;
        end
        m_mode = nxt;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
